// File: rtl/fixedpoint_pkg.sv
// Shared Q-format constants and state encoding for the fixed-point
// multiply/divide pair.
package fixedpoint_pkg;

   // Data width shared by every data port of both blocks.
   localparam int W  = 8;

   // Divider formats: Q6.2 dividend / Q3.5 divisor -> Q3.5 quotient.
   localparam int FI = 2;
   localparam int FD = 5;
   localparam int FQ = 5;

   // The pre-shift aligns the dividend so the integer quotient lands in Q3.5.
   // N is the step count; it includes one extra bit used for rounding.
   localparam int S     = FQ + FD - FI;
   localparam int N     = W + S + 1;
   localparam int CNT_W = $clog2(N);

   // Multiplier formats: Q3.5 x Q3.5 -> Q6.2.
   localparam int MUL_W  = W;
   localparam int MUL_FA = 5;
   localparam int MUL_FB = 5;
   localparam int MUL_FP = 2;

   // Value driven on saturation and on divide-by-zero.
   localparam logic [W-1:0] SAT = {W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/fixedpoint_div_step.sv
// One restoring-division step: shift the next numerator bit into the
// remainder and subtract the divisor when it fits.
module fixedpoint_div_step
   import fixedpoint_pkg::*;
(
   input  logic [W:0]   rem_i,
   input  logic         bit_i,
   input  logic [W-1:0] div_i,
   output logic [W:0]   rem_o,
   output logic         q_o
);

   logic [W+1:0] wide;
   logic [W+1:0] div_ext;

   // Compare and conditionally subtract at full width so nothing is lost.
   always_comb begin
      wide    = {rem_i, bit_i};
      div_ext = {2'b00, div_i};
      q_o     = (wide >= div_ext);
      // The remainder after a step is always below the divisor, so it fits
      // back into W+1 bits.
      rem_o   = q_o ? (W+1)'(wide - div_ext) : wide[W:0];
   end

endmodule

// File: rtl/fixedpoint_div.sv
// Sequential unsigned Q6.2 / Q3.5 -> Q3.5 divider with rounding, saturation
// and a start/busy/done handshake.
module fixedpoint_div
   import fixedpoint_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] in1,
   input  logic [W-1:0] in2,
   output logic [W-1:0] out,
   output logic         busy,
   output logic         done,
   output logic         ovf,
   output logic         dz
);

   state_e             state_q, state_d;
   logic [N-1:0]       num_q,   num_d;
   logic [W-1:0]       div_q,   div_d;
   logic [W:0]         rem_q,   rem_d;
   logic [N-1:0]       quo_q,   quo_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [W-1:0]       out_q,   out_d;
   logic               busy_q,  busy_d;
   logic               done_q,  done_d;
   logic               ovf_q,   ovf_d;
   logic               dz_q,    dz_d;

   logic [W:0]         step_rem;
   logic               step_q;
   logic [N-2:0]       rounded;

   fixedpoint_div_step u_step (
      .rem_i (rem_q),
      .bit_i (num_q[N-1]),
      .div_i (div_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   // Round half-up by adding one at the extra quotient bit and dropping it.
   assign rounded = (N-1)'(({1'b0, quo_q} + (N+1)'(1)) >> 1);

   // Next-state, datapath and output logic of the handshake FSM.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      num_d   = num_q;
      div_d   = div_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      dz_d    = dz_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               num_d   = {in1, {(S+1){1'b0}}};
               div_d   = in2;
               rem_d   = '0;
               quo_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               ovf_d   = 1'b0;
               dz_d    = 1'b0;
               state_d = (in2 == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            num_d = {num_q[N-2:0], 1'b0};
            rem_d = step_rem;
            quo_d = {quo_q[N-2:0], step_q};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N-1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (div_q == '0) begin
               out_d = SAT;
               ovf_d = 1'b0;
               dz_d  = 1'b1;
            end else if (rounded > (N-1)'(SAT)) begin
               out_d = SAT;
               ovf_d = 1'b1;
               dz_d  = 1'b0;
            end else begin
               out_d = rounded[W-1:0];
               ovf_d = 1'b0;
               dz_d  = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; everything is cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         num_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         num_q   <= num_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign done = done_q;
   assign ovf  = ovf_q;
   assign dz   = dz_q;

endmodule

// File: doc/fixedpoint_div.md
Name: fixedpoint_div

Overview:
Sequential unsigned fixed-point divider; the inverse of the existing Q3.5 × Q3.5 → Q6.2 multiplier.
- Takes a Q6.2 product and a Q3.5 divisor, and returns the Q3.5 quotient.
- Uses a restoring shift-subtract datapath with a start/busy/done handshake.
- Used to recover an operand from a product, e.g. c4 / e0 → e0 (49 / 7 = 7).

Parameters:
- W, 8, width of every data port.
- FI, 2, fraction bits of the dividend (in1).
- FD, 5, fraction bits of the divisor (in2).
- FQ, 5, fraction bits of the quotient (out).
- Pre-shift is S = FQ + FD − FI = 8 at defaults. Iteration count is N = W + S + 1 = 17 (includes one rounding bit).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- in1  in  8  dividend, Q6.2 unsigned
- in2  in  8  divisor, Q3.5 unsigned
- out  out  8  quotient, Q3.5 unsigned, rounded half-up, saturating
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; out/ovf/dz valid in that cycle and held afterwards
- ovf  out  1  quotient exceeded 8'hff and was saturated
- dz  out  1  divisor was zero

Behaviour:
- Reset (async, active-high): state=IDLE; out=8'h00, busy=0, done=0, ovf=0, dz=0; internal numerator, remainder, quotient and count registers cleared.
- Arithmetic:
  - Numerator num = {in1, S+1 zero bits}, 17 bits.
  - Q17 = floor(num / in2), computed by restoring division MSB-first, one bit per cycle.
  - The remainder register is 9 bits, so the shifted value never truncates.
  - Rounded result R = (Q17 + 1) >> 1, 16 bits.
  - If R > 255: out=8'hff, ovf=1. Else out=R[7:0], ovf=0.
- States: IDLE, CALC, DONE.
  - IDLE:
    - start=1 at edge E0 latches in1/in2, sets busy=1, and clears done/ovf/dz.
    - If in2 == 0, go to DONE; otherwise go to CALC with count=0.
    - start=0: stay in IDLE. out and flags hold their last values.
  - CALC:
    - Each edge shifts the remainder left, bringing in the next numerator bit.
    - If remainder ≥ in2, subtract in2 and shift 1 into Q17; otherwise shift 0.
    - count increments each edge. After the 17th step (edge E17), go to DONE.
  - DONE, entered at E18 (or at E1 for divide-by-zero):
    - out, ovf and dz are registered, done=1 for exactly that one cycle, busy=0.
    - The next edge returns to IDLE unconditionally.
    - Divide-by-zero: out=8'hff, dz=1, ovf=0.
- Latency: 18 cycles from the start edge to done (1 cycle for divide-by-zero). Throughput: one operation per 19 cycles.
- start while busy=1 (CALC or DONE) is ignored. in1/in2 may change freely after E0.
- start=1 in the IDLE cycle immediately after DONE is accepted normally (back-to-back operation).
- Reset asserted mid-CALC aborts the operation immediately. done does not fire. All outputs return to reset values.
- Outputs are driven only from registers; there is no combinational path from inputs to outputs.

Decomposition:
- Package fixedpoint_pkg holds:
  - Q-format constants (W, FI, FD, FQ, S, N).
  - State encoding IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Saturation value 8'hff.
  - The multiplier's format constants also move into this package, so both blocks share one definition.
- One combinational sub-module, fixedpoint_div_step:
  - Inputs: 9-bit remainder, incoming numerator bit, 8-bit divisor.
  - Outputs: next remainder and quotient bit.
  - Instantiated once in the CALC datapath.
- FSM, counter and rounding/saturation logic stay in the top module.

Test Plan:
- in1=c4, in2=e0, start one cycle → done exactly 18 cycles later; out=e0, ovf=0, dz=0 (49/7 = 7). busy is high for cycles 1–17.
- Back-to-back: 0f/60 → out=28 (3.75/3 = 1.25); start in the cycle after done with 03/10 → out=30 (0.75/0.5 = 1.5). Both results appear with no lost request.
- Rounding: 01/03 → out=55 (85.33 rounds down); 02/03 → out=ab (170.67 rounds up).
- Saturation and divide-by-zero:
  - ff/01 → out=ff, ovf=1, dz=0 after 18 cycles.
  - 40/00 → out=ff, dz=1, ovf=0, done at cycle 1.
- Protocol abuse:
  - Start c4/e0, then pulse start with 0f/60 at cycle 5 → ignored; result is still e0.
  - Separately, assert rst at cycle 9 of a CALC → outputs become 0 immediately and no done pulse occurs.
  - After rst is released, a fresh 0f/60 start yields 28.
